// File: rtl/alu_op_sequencer.sv
// Programmable opcode sequencer in front of the ALU controller: replays up to
// eight stored opcodes as one-cycle execute pulses separated by a settle gap.
module alu_op_sequencer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       prog_we,
    input  logic [2:0] prog_addr,
    input  logic [3:0] prog_op,
    input  logic [3:0] prog_len,
    input  logic       start,
    input  logic       abort,
    output logic       exec_pulse,
    output logic [3:0] op_out,
    output logic       busy,
    output logic       done,
    output logic [2:0] step_idx
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        clamp_len = (len > 4'd8) ? 4'd8 : len;
    endfunction

    logic [1:0] state_r;
    logic [1:0] state_s;
    logic [2:0] idx_r;
    logic [2:0] idx_s;
    logic [3:0] len_r;
    logic [3:0] len_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_s;
    logic       start_q_r;
    logic [3:0] prog_mem_r [8];

    logic       exec_pulse_r;
    logic [3:0] op_out_r;
    logic       busy_r;
    logic       done_r;

    logic       start_edge_s;
    logic [3:0] len_clamp_s;
    logic       wr_en_s;
    logic       busy_next_s;
    logic [3:0] rd_op_s;

    // Edge detect, length clamp and write qualification.
    always_comb begin
        start_edge_s = start & ~start_q_r;
        len_clamp_s  = clamp_len(prog_len);
        wr_en_s      = prog_we && (state_r == IDLE);
    end

    // Next-state logic; abort overrides everything, including a start edge.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        len_s   = len_r;
        cnt_s   = cnt_r;
        if (abort) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_edge_s) begin
                        if (len_clamp_s == 4'd0) begin
                            state_s = DONE;
                        end else begin
                            len_s   = len_clamp_s;
                            idx_s   = 3'd0;
                            state_s = ISSUE;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                ISSUE: begin
                    cnt_s   = SETTLE_M1;
                    state_s = WAIT;
                end
                WAIT: begin
                    if (cnt_r == 4'd0) begin
                        if ({1'b0, idx_r} == (len_r - 4'd1)) begin
                            state_s = DONE;
                        end else begin
                            idx_s   = idx_r + 3'd1;
                            state_s = ISSUE;
                        end
                    end else begin
                        cnt_s = cnt_r - 4'd1;
                    end
                end
                DONE: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Opcode for the next cycle; forwards a same-edge write so a run started
    // together with a buffer write sees the new contents.
    always_comb begin
        busy_next_s = (state_s == ISSUE) || (state_s == WAIT);
        if (wr_en_s && (prog_addr == idx_s)) begin
            rd_op_s = prog_op;
        end else begin
            rd_op_s = prog_mem_r[idx_s];
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            idx_r     <= 3'd0;
            len_r     <= 4'd0;
            cnt_r     <= 4'd0;
            start_q_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            len_r     <= len_s;
            cnt_r     <= cnt_s;
            start_q_r <= start;
        end
    end

    // Program buffer storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                prog_mem_r[i] <= 4'h0;
            end
        end else if (wr_en_s) begin
            prog_mem_r[prog_addr] <= prog_op;
        end
    end

    // Outputs registered from the next state so they match a Moore decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_pulse_r <= 1'b0;
            op_out_r     <= 4'h0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            exec_pulse_r <= (state_s == ISSUE);
            op_out_r     <= busy_next_s ? rd_op_s : 4'h0;
            busy_r       <= busy_next_s;
            done_r       <= (state_s == DONE);
        end
    end

    assign exec_pulse = exec_pulse_r;
    assign op_out     = op_out_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign step_idx   = idx_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; two instances cover SETTLE=2 and SETTLE=1.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       prog_we;
    logic [2:0] prog_addr;
    logic [3:0] prog_op;
    logic [3:0] prog_len;
    logic       start;
    logic       abort;

    logic       exec_a, busy_a, done_a;
    logic [3:0] op_a;
    logic [2:0] idx_a;
    logic       exec_b, busy_b, done_b;
    logic [3:0] op_b;
    logic [2:0] idx_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] ops_zero [8];
    logic [3:0] ops_a [8];
    logic [3:0] ops_b [8];
    logic [3:0] ops_c [8];
    logic [3:0] ops_d [8];

    always #5 clk = ~clk;

    alu_op_sequencer #(.SETTLE(2)) u_dut_s2 (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_op(prog_op), .prog_len(prog_len), .start(start), .abort(abort),
        .exec_pulse(exec_a), .op_out(op_a), .busy(busy_a), .done(done_a),
        .step_idx(idx_a)
    );

    alu_op_sequencer #(.SETTLE(1)) u_dut_s1 (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_op(prog_op), .prog_len(prog_len), .start(start), .abort(abort),
        .exec_pulse(exec_b), .op_out(op_b), .busy(busy_b), .done(done_b),
        .step_idx(idx_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed view {exec, busy, done, op[3:0], idx[2:0]} of the selected instance.
    function automatic logic [9:0] obs(input int settle);
        if (settle == 1) return {exec_b, busy_b, done_b, op_b, idx_b};
        else             return {exec_a, busy_a, done_a, op_a, idx_a};
    endfunction

    task automatic write_op(input logic [2:0] a, input logic [3:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_op   = d;
        step();
        prog_we   = 1'b0;
    endtask

    // Starts a run and checks every cycle after edge 0 against the timing model.
    task automatic run_prog(input string tag, input int settle, input int plen,
                            input int len, input logic [3:0] ops [8],
                            input int prior_idx, input bit hold, input int inj_e);
        int         period;
        int         total;
        int         n_cyc;
        logic [9:0] exp;
        logic [2:0] last_idx;
        period   = 1 + settle;
        total    = len * period;
        n_cyc    = hold ? 20 : total + 3;
        last_idx = (len > 0) ? 3'(len - 1) : 3'(prior_idx);
        prog_len = 4'(plen);
        start    = 1'b0;
        step();
        start    = 1'b1;
        step();
        for (int e = 0; e < n_cyc; e++) begin
            if (e < total)
                exp = {(e % period == 0), 1'b1, 1'b0, ops[e / period], 3'(e / period)};
            else if (e == total)
                exp = {3'b001, 4'h0, last_idx};
            else
                exp = {3'b000, 4'h0, last_idx};
            check($sformatf("%s_e%0d", tag, e), 32'(obs(settle)), 32'(exp));
            if (e == 0 && !hold) start = 1'b0;
            if (e == inj_e) begin
                prog_we   = 1'b1;
                prog_addr = 3'd2;
                prog_op   = 4'hA;
                start     = 1'b1;
            end
            if (e == inj_e + 1) begin
                prog_we = 1'b0;
                start   = 1'b0;
            end
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; prog_we = 1'b0; prog_addr = 3'd0; prog_op = 4'h0;
        prog_len = 4'd0; start = 1'b0; abort = 1'b0;
        ops_zero = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        ops_a    = '{4'hF, 4'hE, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        ops_b    = '{4'h5, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        ops_c    = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        ops_d    = '{4'h9, 4'hA, 4'hB, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        idle(2);
        check("reset_s2", 32'(obs(2)), 32'd0);
        check("reset_s1", 32'(obs(1)), 32'd0);
        reset = 1'b0;
        step();

        // Macro F,E,F,0 then asynchronous reset in the middle of a second run.
        write_op(3'd0, 4'hF); write_op(3'd1, 4'hE);
        write_op(3'd2, 4'hF); write_op(3'd3, 4'h0);
        run_prog("run4", 2, 4, 4, ops_a, 0, 1'b0, -1);
        idle(15);
        start = 1'b1; step(); start = 1'b0;
        idle(3);
        check("mid_run", 32'(obs(2)), 32'({3'b110, 4'hE, 3'd1}));
        reset = 1'b1;
        #1;
        check("async_rst_s2", 32'(obs(2)), 32'd0);
        check("async_rst_s1", 32'(obs(1)), 32'd0);
        step();
        reset = 1'b0;
        step();
        run_prog("post_rst", 2, 1, 1, ops_zero, 0, 1'b0, -1);
        idle(15);

        // Held start gives one run; a fresh edge gives another.
        write_op(3'd0, 4'h5); write_op(3'd1, 4'h6);
        run_prog("held", 2, 2, 2, ops_b, 0, 1'b1, -1);
        idle(3);
        run_prog("rerun", 2, 2, 2, ops_b, 0, 1'b0, -1);
        idle(15);

        // Abort in the WAIT after opcode 1.
        write_op(3'd0, 4'h1); write_op(3'd1, 4'h2);
        write_op(3'd2, 4'h3); write_op(3'd3, 4'h4);
        prog_len = 4'd4;
        start = 1'b1; step(); start = 1'b0;
        idle(4);
        check("abort_pre", 32'(obs(2)), 32'({3'b010, 4'h2, 3'd1}));
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("abort_post_%0d", i), 32'(obs(2)), 32'({3'b000, 4'h0, 3'd1}));
            step();
        end
        idle(5);

        // Zero and oversize program length.
        run_prog("len0", 2, 0, 0, ops_c, 1, 1'b0, -1);
        idle(15);
        write_op(3'd4, 4'h5); write_op(3'd5, 4'h6);
        write_op(3'd6, 4'h7); write_op(3'd7, 4'h8);
        run_prog("len12", 2, 12, 8, ops_c, 0, 1'b0, -1);
        idle(15);

        // Write and start edge while busy are both ignored.
        run_prog("lockout", 2, 4, 4, ops_c, 0, 1'b0, 4);
        idle(15);
        run_prog("relock", 2, 4, 4, ops_c, 0, 1'b0, -1);
        idle(15);

        // Minimum settle on the SETTLE=1 instance.
        write_op(3'd0, 4'h9); write_op(3'd1, 4'hA); write_op(3'd2, 4'hB);
        run_prog("settle1", 1, 3, 3, ops_d, 0, 1'b0, -1);
        idle(15);

        // Abort together with a start edge in IDLE.
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("abort_start_s2_%0d", i), 32'(obs(2)), 32'({3'b000, 4'h0, 3'd2}));
            check($sformatf("abort_start_s1_%0d", i), 32'(obs(1)), 32'({3'b000, 4'h0, 3'd2}));
            step();
        end
        start = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
